// File: rtl/ucode_seq_ctrl_pkg.sv
// ucode_seq_ctrl_pkg: shared types and constants for the ucode sequencer.
//   - seq_state_e   : sequencer FSM states (IDLE, RUN, FINISH)
//   - loop_frame_t  : one hardware-loop frame {start_addr, end_addr, remaining}
//   - im_addr_t / instruction_t : instruction memory address and word types
//   - LOOP_CNT_WIDTH_DEFAULT    : default loop iteration count width
package ucode_seq_ctrl_pkg;

  localparam int LOOP_CNT_WIDTH_DEFAULT = 8;
  localparam int IM_ADDR_WIDTH_DEFAULT  = 4;
  localparam int INSTR_WIDTH            = 16;

  typedef logic [IM_ADDR_WIDTH_DEFAULT-1:0] im_addr_t;
  typedef logic [INSTR_WIDTH-1:0]           instruction_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } seq_state_e;

  // Frame layout at the default widths; the stack itself is parameterised
  // and stores the same three fields in separate arrays.
  typedef struct packed {
    im_addr_t                          start_addr;
    im_addr_t                          end_addr;
    logic [LOOP_CNT_WIDTH_DEFAULT-1:0] remaining;
  } loop_frame_t;

endpackage

// File: rtl/ucode_seq_ctrl_loop_stack.sv
// ucode_seq_ctrl_loop_stack: LIFO of hardware-loop frames.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   clear_i                 empty the stack (highest priority)
//   push_i + push_*_i       push a frame {start, end, remaining}
//   pop_i                   drop the top frame
//   dec_i                   decrement the top frame's remaining count
//   top_*_o                 top frame fields (zero when empty)
//   empty_o, full_o         occupancy flags
module ucode_seq_ctrl_loop_stack #(
  parameter int IM_ADDR_WIDTH    = 4,
  parameter int LOOP_CNT_WIDTH   = 8,
  parameter int LOOP_STACK_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic [IM_ADDR_WIDTH-1:0]  push_start_i,
  input  logic [IM_ADDR_WIDTH-1:0]  push_end_i,
  input  logic [LOOP_CNT_WIDTH-1:0] push_rem_i,
  input  logic                      pop_i,
  input  logic                      dec_i,
  output logic [IM_ADDR_WIDTH-1:0]  top_start_o,
  output logic [IM_ADDR_WIDTH-1:0]  top_end_o,
  output logic [LOOP_CNT_WIDTH-1:0] top_rem_o,
  output logic                      empty_o,
  output logic                      full_o
);

  localparam int CNT_W = $clog2(LOOP_STACK_DEPTH + 1);
  localparam int IDX_W = (LOOP_STACK_DEPTH > 1) ? $clog2(LOOP_STACK_DEPTH) : 1;

  logic [IM_ADDR_WIDTH-1:0]  start_q [LOOP_STACK_DEPTH];
  logic [IM_ADDR_WIDTH-1:0]  start_d [LOOP_STACK_DEPTH];
  logic [IM_ADDR_WIDTH-1:0]  end_q   [LOOP_STACK_DEPTH];
  logic [IM_ADDR_WIDTH-1:0]  end_d   [LOOP_STACK_DEPTH];
  logic [LOOP_CNT_WIDTH-1:0] rem_q   [LOOP_STACK_DEPTH];
  logic [LOOP_CNT_WIDTH-1:0] rem_d   [LOOP_STACK_DEPTH];
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          top_idx, push_idx;

  assign empty_o  = (cnt_q == CNT_W'(0));
  assign full_o   = (cnt_q == CNT_W'(LOOP_STACK_DEPTH));
  assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
  assign push_idx = IDX_W'(cnt_q);

  // Top-of-stack read port; an empty stack presents zeros.
  always_comb begin
    if (empty_o) begin
      top_start_o = {IM_ADDR_WIDTH{1'b0}};
      top_end_o   = {IM_ADDR_WIDTH{1'b0}};
      top_rem_o   = {LOOP_CNT_WIDTH{1'b0}};
    end else begin
      top_start_o = start_q[top_idx];
      top_end_o   = end_q[top_idx];
      top_rem_o   = rem_q[top_idx];
    end
  end

  // Next-state for occupancy and frame storage: clear > push > pop > dec.
  always_comb begin
    cnt_d   = cnt_q;
    start_d = start_q;
    end_d   = end_q;
    rem_d   = rem_q;
    if (clear_i) begin
      cnt_d = CNT_W'(0);
    end else if (push_i && !full_o) begin
      start_d[push_idx] = push_start_i;
      end_d[push_idx]   = push_end_i;
      rem_d[push_idx]   = push_rem_i;
      cnt_d             = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (dec_i && !empty_o) begin
      rem_d[top_idx] = rem_q[top_idx] - LOOP_CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stack storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_W'(0);
      for (int i = 0; i < LOOP_STACK_DEPTH; i++) begin
        start_q[i] <= {IM_ADDR_WIDTH{1'b0}};
        end_q[i]   <= {IM_ADDR_WIDTH{1'b0}};
        rem_q[i]   <= {LOOP_CNT_WIDTH{1'b0}};
      end
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
      end_q   <= end_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: rtl/ucode_seq_ctrl.sv
// ucode_seq_ctrl: ucode instruction sequencer with nested hardware loops.
// Owns the instruction memory's single address/write port: in IDLE it
// passes host configuration writes through, in RUN it drives the PC.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i                       begin execution at address 0 (IDLE only)
//   busy_o, done_o, error_o       status: RUN/FINISH, FINISH pulse, sticky loop error
//   cfg_valid_i/cfg_ready_o, cfg_addr_i, cfg_data_i   host write port
//   im_we_o, im_addr_o, im_wdata_o                    instruction memory port
//   dec_is_loop_i, dec_loop_iter_i, dec_loop_end_i, dec_is_end_i  decoder view of instr at im_addr_o
//   stall_i, instr_valid_o        issue handshake with the datapath
//   cycles_o                      RUN cycle counter (only with UCODE_SEQ_PERF_CNT_EN)
// Optional feature macro: UCODE_SEQ_PERF_CNT_EN.
module ucode_seq_ctrl
  import ucode_seq_ctrl_pkg::*;
#(
  parameter int IM_ADDR_WIDTH    = 4,
  parameter int LOOP_CNT_WIDTH   = LOOP_CNT_WIDTH_DEFAULT,
  parameter int LOOP_STACK_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [IM_ADDR_WIDTH-1:0]  cfg_addr_i,
  input  instruction_t              cfg_data_i,
  output logic                      im_we_o,
  output logic [IM_ADDR_WIDTH-1:0]  im_addr_o,
  output instruction_t              im_wdata_o,
  input  logic                      dec_is_loop_i,
  input  logic [LOOP_CNT_WIDTH-1:0] dec_loop_iter_i,
  input  logic [IM_ADDR_WIDTH-1:0]  dec_loop_end_i,
  input  logic                      dec_is_end_i,
  input  logic                      stall_i,
  output logic                      instr_valid_o
`ifdef UCODE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]               cycles_o
`endif
);

  seq_state_e                state_q, state_d;
  logic [IM_ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                      error_q, error_d;

  logic                      stk_clear, stk_push, stk_pop, stk_dec;
  logic [IM_ADDR_WIDTH-1:0]  top_start, top_end;
  logic [LOOP_CNT_WIDTH-1:0] top_rem;
  logic                      stk_empty, stk_full;

  logic [IM_ADDR_WIDTH-1:0]  pc_plus1, end_plus1;
  logic [LOOP_CNT_WIDTH-1:0] iter_minus1;
  logic                      at_loop_end;

  // Address arithmetic wraps modulo 2^IM_ADDR_WIDTH by construction.
  assign pc_plus1    = pc_q + IM_ADDR_WIDTH'(1);
  assign end_plus1   = dec_loop_end_i + IM_ADDR_WIDTH'(1);
  assign iter_minus1 = dec_loop_iter_i - LOOP_CNT_WIDTH'(1);
  assign at_loop_end = !stk_empty && (pc_q == top_end);

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == FINISH);
  assign error_o       = error_q;
  assign cfg_ready_o   = (state_q == IDLE);
  assign instr_valid_o = (state_q == RUN) && !stall_i;
  assign im_we_o       = cfg_valid_i && cfg_ready_o;
  assign im_addr_o     = cfg_ready_o ? cfg_addr_i : pc_q;
  assign im_wdata_o    = cfg_data_i;

  ucode_seq_ctrl_loop_stack #(
    .IM_ADDR_WIDTH   (IM_ADDR_WIDTH),
    .LOOP_CNT_WIDTH  (LOOP_CNT_WIDTH),
    .LOOP_STACK_DEPTH(LOOP_STACK_DEPTH)
  ) u_loop_stack (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (stk_clear),
    .push_i      (stk_push),
    .push_start_i(pc_plus1),
    .push_end_i  (dec_loop_end_i),
    .push_rem_i  (iter_minus1),
    .pop_i       (stk_pop),
    .dec_i       (stk_dec),
    .top_start_o (top_start),
    .top_end_o   (top_end),
    .top_rem_o   (top_rem),
    .empty_o     (stk_empty),
    .full_o      (stk_full)
  );

  // FSM next state, PC sequencing and loop-stack control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    error_d   = error_q;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          pc_d      = {IM_ADDR_WIDTH{1'b0}};
          error_d   = 1'b0;
          stk_clear = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (instr_valid_o) begin
          if (dec_is_end_i) begin
            state_d = FINISH;
          end else if (dec_is_loop_i) begin
            // A LOOP sitting on the top frame's end address is treated
            // purely as a LOOP; the end-of-body check is not applied.
            if (dec_loop_iter_i == {LOOP_CNT_WIDTH{1'b0}}) begin
              pc_d = end_plus1;
            end else if (stk_full) begin
              error_d = 1'b1;
              state_d = FINISH;
            end else if (!stk_empty && (dec_loop_end_i >= top_end)) begin
              // Inner body must close strictly before the enclosing one.
              error_d = 1'b1;
              state_d = FINISH;
            end else begin
              stk_push = 1'b1;
              pc_d     = pc_plus1;
            end
          end else if (at_loop_end) begin
            if (top_rem != {LOOP_CNT_WIDTH{1'b0}}) begin
              stk_dec = 1'b1;
              pc_d    = top_start;
            end else begin
              stk_pop = 1'b1;
              pc_d    = pc_plus1;
            end
          end else begin
            pc_d = pc_plus1;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= {IM_ADDR_WIDTH{1'b0}};
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      error_q <= error_d;
    end
  end

`ifdef UCODE_SEQ_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  assign cycles_o = cycles_q;

  // RUN cycle counter: cleared on start, saturating, frozen outside RUN.
  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == IDLE) && start_i) begin
      cycles_d = 32'd0;
    end else if ((state_q == RUN) && (cycles_q != 32'hFFFF_FFFF)) begin
      cycles_d = cycles_q + 32'd1;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end
`endif

endmodule

// File: tb/tb_ucode_seq_ctrl.sv
// tb_ucode_seq_ctrl: self-checking bench for ucode_seq_ctrl.
// The bench models the instruction memory (registered write, combinational
// read) and a tiny decoder: [15:14] opcode (00 NOP, 01 LOOP, 10 END),
// [13:6] iteration count N, [3:0] loop end address E.
module tb_ucode_seq_ctrl;
  import ucode_seq_ctrl_pkg::*;

  logic         clk, rst_n, start_i, cfg_valid_i, stall_i;
  logic [3:0]   cfg_addr_i;
  instruction_t cfg_data_i;
  logic         busy_o, done_o, error_o, cfg_ready_o, im_we_o, instr_valid_o;
  logic [3:0]   im_addr_o;
  instruction_t im_wdata_o;
  logic         dec_is_loop_i, dec_is_end_i;
  logic [7:0]   dec_loop_iter_i;
  logic [3:0]   dec_loop_end_i;
`ifdef UCODE_SEQ_PERF_CNT_EN
  logic [31:0]  cycles_o;
`endif

  int checks = 0;
  int errors = 0;

  instruction_t mem  [16];
  instruction_t prog [16];
  logic [3:0]   exp_q [$];

  ucode_seq_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_data_i     (cfg_data_i),
    .im_we_o        (im_we_o),
    .im_addr_o      (im_addr_o),
    .im_wdata_o     (im_wdata_o),
    .dec_is_loop_i  (dec_is_loop_i),
    .dec_loop_iter_i(dec_loop_iter_i),
    .dec_loop_end_i (dec_loop_end_i),
    .dec_is_end_i   (dec_is_end_i),
    .stall_i        (stall_i),
    .instr_valid_o  (instr_valid_o)
`ifdef UCODE_SEQ_PERF_CNT_EN
    ,
    .cycles_o       (cycles_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_we_o) mem[im_addr_o] <= im_wdata_o;
  end

  always_comb begin
    instruction_t cur;
    cur             = mem[im_addr_o];
    dec_is_loop_i   = (cur[15:14] == 2'b01);
    dec_is_end_i    = (cur[15:14] == 2'b10);
    dec_loop_iter_i = cur[13:6];
    dec_loop_end_i  = cur[3:0];
  end

  function automatic instruction_t enc_loop(input logic [7:0] n, input logic [3:0] e);
    return {2'b01, n, 2'b00, e};
  endfunction
  function automatic instruction_t enc_end();
    return {2'b10, 14'd0};
  endfunction
  function automatic instruction_t enc_nop();
    return 16'h0000;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = enc_nop();
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      cfg_valid_i = 1'b1;
      cfg_addr_i  = 4'(i);
      cfg_data_i  = prog[i];
    end
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  // Start the program and follow it to done_o, popping expected issue
  // addresses from exp_q. Optional stall window, busy-time writes and a
  // write issued together with start.
  task automatic run_prog(input string name, input int stall_from, input int stall_len,
                          input bit busy_wr, input bit start_wr, input instruction_t start_data,
                          input bit exp_err);
    logic [3:0] exp;
    bit done_seen;
    int last_issue, done_cyc;
    done_seen  = 1'b0;
    last_issue = -10;
    done_cyc   = -1;
    @(posedge clk); #1;
    start_i = 1'b1;
    if (start_wr) begin
      cfg_valid_i = 1'b1;
      cfg_addr_i  = 4'd0;
      cfg_data_i  = start_data;
      #1;
      checks++;
      if (im_we_o !== 1'b1) begin
        errors++;
        $display("FAIL %s start_write_we: got %b expected 1", name, im_we_o);
      end
    end
    @(posedge clk); #1;
    start_i     = 1'b0;
    cfg_valid_i = busy_wr;
    cfg_addr_i  = 4'd0;
    cfg_data_i  = enc_end();
    for (int cyc = 0; cyc < 80 && !done_seen; cyc++) begin
      stall_i = (cyc >= stall_from) && (cyc < stall_from + stall_len);
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (error_o !== 1'b0 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL %s run_entry: got err=%b busy=%b expected err=0 busy=1", name, error_o, busy_o);
        end
      end
      if (busy_wr) begin
        checks++;
        if (cfg_ready_o !== 1'b0 || im_we_o !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_write: got ready=%b we=%b expected 0 0", name, cfg_ready_o, im_we_o);
        end
      end
      if (stall_i) begin
        checks++;
        if (instr_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_valid: got %b expected 0", name, instr_valid_o);
        end
        if (exp_q.size() > 0) begin
          checks++;
          if (im_addr_o !== exp_q[0]) begin
            errors++;
            $display("FAIL %s stall_pc: got %0d expected %0d", name, im_addr_o, exp_q[0]);
          end
        end
      end else if (instr_valid_o === 1'b1) begin
        last_issue = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_issue: got pc %0d expected none", name, im_addr_o);
        end else begin
          exp = exp_q.pop_front();
          if (im_addr_o !== exp) begin
            errors++;
            $display("FAIL %s issue_pc: got %0d expected %0d", name, im_addr_o, exp);
          end
        end
      end
      if (done_o === 1'b1) begin
        done_seen   = 1'b1;
        done_cyc    = cyc;
        cfg_valid_i = 1'b0;
        checks++;
        if (error_o !== exp_err) begin
          errors++;
          $display("FAIL %s error_flag: got %b expected %b", name, error_o, exp_err);
        end
      end
      @(posedge clk); #1;
    end
    stall_i     = 1'b0;
    cfg_valid_i = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s done_timeout: got no done expected done within 80 cycles", name);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_issues: got %0d left expected 0", name, exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (done_cyc != last_issue + 1) begin
      errors++;
      $display("FAIL %s done_latency: got cycle %0d expected %0d", name, done_cyc, last_issue + 1);
    end
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done: got busy=%b done=%b ready=%b expected 0 0 1", name, busy_o, done_o, cfg_ready_o);
    end
`ifdef UCODE_SEQ_PERF_CNT_EN
    checks++;
    if (cycles_o !== 32'(done_cyc)) begin
      errors++;
      $display("FAIL %s cycles: got %0d expected %0d", name, cycles_o, done_cyc);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; cfg_valid_i = 1'b0; stall_i = 1'b0;
    cfg_addr_i = 4'd9; cfg_data_i = 16'h0;
    #12;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || instr_valid_o !== 1'b0 || im_we_o !== 1'b0 ||
        cfg_ready_o !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b vld=%b we=%b rdy=%b err=%b expected 0 0 0 0 1 0",
               busy_o, done_o, instr_valid_o, im_we_o, cfg_ready_o, error_o);
    end
    checks++;
    if (im_addr_o !== 4'd9) begin
      errors++;
      $display("FAIL reset_addr_mux: got %0d expected 9", im_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_run();
    clear_prog();
    prog[2] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd1, 4'd2};
    run_prog("load_run", 99, 0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_single_loop();
    clear_prog();
    prog[0] = enc_loop(8'd3, 4'd2);
    prog[3] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3};
    run_prog("single_loop", 99, 0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_nested_loop();
    clear_prog();
    prog[0] = enc_loop(8'd2, 4'd4);
    prog[1] = enc_loop(8'd2, 4'd2);
    prog[5] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5};
    run_prog("nested_loop", 99, 0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_zero_loop();
    clear_prog();
    prog[0] = enc_loop(8'd0, 4'd3);
    prog[3] = enc_end();
    prog[4] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd4};
    run_prog("zero_loop", 99, 0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_overflow();
    clear_prog();
    prog[0] = enc_loop(8'd1, 4'd5);
    prog[1] = enc_loop(8'd1, 4'd4);
    prog[2] = enc_loop(8'd1, 4'd3);
    prog[7] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd1, 4'd2};
    run_prog("overflow", 99, 0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (error_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b expected 1", error_o);
    end
  endtask

  task automatic test_nest_error();
    clear_prog();
    prog[0] = enc_loop(8'd2, 4'd3);
    prog[1] = enc_loop(8'd2, 4'd3);
    prog[6] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd1};
    run_prog("nest_error", 99, 0, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_stall();
    clear_prog();
    prog[0] = enc_loop(8'd3, 4'd2);
    prog[3] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3};
    run_prog("stall", 3, 3, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_start_with_write();
    clear_prog();
    prog[1] = enc_end();
    load_prog();
    exp_q = '{4'd0};
    run_prog("start_write", 99, 0, 1'b0, 1'b1, enc_end(), 1'b0);
  endtask

  task automatic test_busy_write();
    clear_prog();
    prog[0] = enc_loop(8'd2, 4'd1);
    prog[2] = enc_end();
    load_prog();
    exp_q = '{4'd0, 4'd1, 4'd1, 4'd2};
    run_prog("busy_write", 99, 0, 1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    clear_prog();
    prog[0] = enc_loop(8'd5, 4'd2);
    prog[3] = enc_end();
    load_prog();
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || instr_valid_o !== 1'b0 || cfg_ready_o !== 1'b1 ||
        im_we_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b vld=%b rdy=%b we=%b err=%b expected 0 0 0 1 0 0",
               busy_o, done_o, instr_valid_o, cfg_ready_o, im_we_o, error_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: got done=%b busy=%b expected 0 0", done_o, busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_single_loop();
    test_nested_loop();
    test_zero_loop();
    test_overflow();
    test_stall();
    test_nest_error();
    test_start_with_write();
    test_busy_write();
    test_reset_mid_run();
    test_load_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
